// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned IMM_W_DEF  = 12;
  localparam int unsigned OPC_W_DEF  = 4;

  // Direct-jump opcode recognised at fetch time.
  localparam logic [OPC_W_DEF-1:0] JMP_OPC_DEF = 4'b1101;

  // One buffered fetch result at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with a registered head word (first-word fall-through).
// The head register keeps its last value once the FIFO runs empty.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  // Pointer/count bookkeeping and next head word.
  always_comb begin
    do_pop  = pop && (count_q != '0) && !flush;
    do_push = push && !flush && ((count_q < CW'(DEPTH)) || do_pop);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    rd_d    = flush ? wr_q : rd_q + PW'(do_pop);
    wr_d    = wr_q + PW'(do_push);
    head_d  = head_q;
    if (count_d != '0) begin
      // When the FIFO would otherwise be empty the new head is the word being written.
      if ((count_q - CW'(do_pop)) == '0) head_d = wdata;
      else                               head_d = mem_q[rd_d];
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = head_q;
  assign count = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: issues in-order fetches, buffers {pc, instr} results,
// follows direct jumps at fetch time and flushes on execute-stage redirects.
module if_prefetch
  import if_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter int unsigned       IMM_W    = IMM_W_DEF,
  parameter int unsigned       OPC_W    = OPC_W_DEF,
  parameter logic [OPC_W-1:0]  JMP_OPC  = OPC_W'(JMP_OPC_DEF),
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_rdata;
  logic [ADDR_W-1:0] imm_sext, jump_target;
  logic              issue, accept, is_jump, pop;

  // Issue gating, response acceptance, predecode and PC/counter next state.
  always_comb begin
    // Every outstanding request owns a FIFO slot, so the FIFO can never overflow.
    imem_req    = !hlt && !rst &&
                  (({1'b0, fifo_count} + {1'b0, outst_q}) < (CW + 1)'(DEPTH));
    imem_addr   = fetch_pc_q;
    issue       = imem_req && imem_gnt;
    accept      = imem_rvalid && (drop_q == '0) && !redirect_valid;
    is_jump     = accept && (imem_rdata[DATA_W-1 -: OPC_W] == JMP_OPC);
    imm_sext    = {{(ADDR_W - IMM_W){imem_rdata[IMM_W-1]}}, imem_rdata[IMM_W-1:0]};
    jump_target = resp_pc_q + ADDR_W'(1) + imm_sext;
    outst_d     = outst_q + CW'(issue) - CW'(imem_rvalid);

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (accept) resp_pc_d = resp_pc_q + ADDR_W'(1);

    // Any request still in flight after a change of flow is wrong-path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = outst_d;
    end else if (is_jump) begin
      fetch_pc_d = jump_target;
      resp_pc_d  = jump_target;
      drop_d     = outst_d;
    end

    pop       = out_valid && out_ready && !redirect_valid;
    out_valid = (fifo_count != '0);
    out_pc    = fifo_rdata[EW-1 -: ADDR_W];
    out_instr = fifo_rdata[DATA_W-1:0];
    busy      = (outst_q != '0) || (fifo_count != '0);
  end

  // Fetch/response PC and request-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  if_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({resp_pc_q, imem_rdata}),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: an in-order latency memory plus a queue-based model of
// the fetch stream where each in-flight request is marked dead on a change of flow.
module tb_if_prefetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst, hlt, redirect_valid, out_ready;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic        out_valid, busy;
  logic [15:0] out_instr, out_pc;

  always #5 clk = ~clk;

  if_prefetch #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEPTH    (4),
    .IMM_W    (12),
    .OPC_W    (4),
    .JMP_OPC  (4'b1101),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hlt            (hlt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          dead;
  } req_t;

  req_t         rq[$];
  fetch_entry_t efifo[$];
  logic [15:0]  dlog[$];
  logic [15:0]  prog [logic [15:0]];
  logic [15:0]  efetch;
  int           cyc, lat, gnt_mode, idx;
  int           checks, errors;
  bit           chk_en;

  function automatic logic [15:0] word(input logic [15:0] a);
    if (prog.exists(a)) return prog[a];
    return {4'h2, a[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_log(input string name, input int i, input logic [15:0] exp);
    if (i >= dlog.size()) begin
      checks++;
      errors++;
      $display("FAIL %s got <none> expected %h", name, exp);
    end else begin
      chk(name, {16'h0, dlog[i]}, {16'h0, exp});
    end
  endtask

  // One clock: drive memory, snapshot just before the edge, advance the model.
  task automatic tick();
    bit          s_req, s_gnt, s_rv, s_rst, s_redir, s_ready, acc, jmp;
    logic [15:0] s_addr, s_rpc, rpc, w, tgt;
    fetch_entry_t e;
    imem_rvalid = (rq.size() > 0) && (rq[0].due <= cyc);
    imem_rdata  = imem_rvalid ? word(rq[0].addr) : 16'h0000;
    imem_gnt    = (gnt_mode == 0) ? 1'b1 : cyc[0];
    #3;
    s_req = imem_req; s_gnt = imem_gnt; s_addr = imem_addr; s_rv = imem_rvalid;
    s_rst = rst; s_redir = redirect_valid; s_rpc = redirect_pc; s_ready = out_ready;
    @(posedge clk);
    cyc++;
    if (s_rst) begin
      efifo.delete();
      rq.delete();
      efetch = 16'h0000;
    end else begin
      acc = 1'b0; jmp = 1'b0; rpc = 16'h0;
      if (s_rv) begin
        acc = !rq[0].dead && !s_redir;
        rpc = rq[0].addr;
        void'(rq.pop_front());
      end
      if (s_req && s_gnt) rq.push_back('{addr: s_addr, due: cyc + lat - 1, dead: 1'b0});
      if (s_redir) begin
        efifo.delete();
        foreach (rq[i]) rq[i].dead = 1'b1;
        efetch = s_rpc;
      end else begin
        if ((efifo.size() > 0) && s_ready) void'(efifo.pop_front());
        if (acc) begin
          w = word(rpc);
          e.pc = rpc;
          e.instr = w;
          efifo.push_back(e);
          if (w[15:12] == 4'hD) begin
            jmp = 1'b1;
            foreach (rq[i]) rq[i].dead = 1'b1;
            tgt = rpc + 16'd1 + {{4{w[11]}}, w[11:0]};
            efetch = tgt;
          end
        end
        if (!jmp && s_req && s_gnt) efetch = efetch + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dlog.delete();
  endtask

  // Per-cycle comparison against the model, mid low phase.
  always @(negedge clk) begin
    bit   ev, ereq;
    #3;
    if (chk_en) begin
      ev = (efifo.size() > 0);
      chk("out_valid", {31'h0, out_valid}, {31'h0, ev});
      if (ev) begin
        chk("out_pc", {16'h0, out_pc}, {16'h0, efifo[0].pc});
        chk("out_instr", {16'h0, out_instr}, {16'h0, efifo[0].instr});
      end
      chk("busy", {31'h0, busy}, {31'h0, (efifo.size() > 0) || (rq.size() > 0)});
      ereq = !hlt && !rst && ((efifo.size() + rq.size()) < 4);
      chk("imem_req", {31'h0, imem_req}, {31'h0, ereq});
      if (ereq) chk("imem_addr", {16'h0, imem_addr}, {16'h0, efetch});
      if (out_valid && out_ready && !redirect_valid && !rst) dlog.push_back(out_pc);
    end
  end

  initial begin
    rst = 1'b1; hlt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; out_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0;
    lat = 1; gnt_mode = 0; cyc = 0; efetch = 16'h0; checks = 0; errors = 0; chk_en = 1'b0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_out_pc", {16'h0, out_pc}, 32'h0);
    chk("rst_out_instr", {16'h0, out_instr}, 32'h0);
    chk("rst_imem_addr", {16'h0, imem_addr}, 32'h0);

    // Streaming, latency 1, always granted.
    repeat (12) tick();
    for (int i = 0; i < 8; i++) chk_log("seq_pc", i, 16'(i));

    // Back-pressure: four buffered, then fetch stops.
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    #1;
    chk("full_req", {31'h0, imem_req}, 32'h0);
    chk("full_valid", {31'h0, out_valid}, 32'h1);
    chk("full_head", {16'h0, out_pc}, 32'h0);
    out_ready = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 6; i++) chk_log("drain_pc", i, 16'(i));

    // Forward and backward direct jumps at pc 5.
    prog[16'h0005] = 16'hD003;
    do_reset();
    repeat (14) tick();
    chk_log("jmp_fwd_5", 5, 16'h0005);
    chk_log("jmp_fwd_9", 6, 16'h0009);
    chk_log("jmp_fwd_10", 7, 16'h000A);
    prog[16'h0005] = 16'hDFFE;
    do_reset();
    repeat (16) tick();
    chk_log("jmp_back_4", 6, 16'h0004);
    chk_log("jmp_back_5", 7, 16'h0005);
    chk_log("jmp_back_4b", 8, 16'h0004);
    prog.delete();

    // Redirect with latency 3 while requests are in flight, then halt and drain.
    do_reset();
    lat = 3;
    repeat (8) tick();
    idx = dlog.size();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    chk_log("redir_pc0", idx, 16'h0040);
    chk_log("redir_pc1", idx + 1, 16'h0041);
    hlt = 1'b1;
    repeat (8) tick();
    #1;
    chk("hlt_req", {31'h0, imem_req}, 32'h0);
    chk("hlt_busy", {31'h0, busy}, 32'h0);
    hlt = 1'b0;

    // Alternating grant, latency 1.
    lat = 1;
    gnt_mode = 1;
    do_reset();
    repeat (12) tick();
    chk_log("gnt_alt_0", 0, 16'h0000);
    chk_log("gnt_alt_1", 1, 16'h0001);
    gnt_mode = 0;

    // PC wrap via redirect near the top of the address space.
    idx = dlog.size();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    chk_log("wrap_fffe", idx, 16'hFFFE);
    chk_log("wrap_ffff", idx + 1, 16'hFFFF);
    chk_log("wrap_0000", idx + 2, 16'h0000);

    // Halt mid-stream, then resume.
    hlt = 1'b1;
    repeat (3) tick();
    hlt = 1'b0;
    repeat (4) tick();

    // Reset mid-stream.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_addr", {16'h0, imem_addr}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Parametrised instruction-fetch stage with a prefetch buffer. It decouples instruction memory from decode using a request/grant memory port, an in-order response path, a DEPTH-entry {pc, instr} FIFO and a valid/ready output handshake. It predecodes direct jumps at fetch time and accepts redirects (branch target or register jump) from execute, flushing wrong-path work. It sits between the PC/instruction-memory path and the decode pipeline register.

Parameters:
DATA_W, 16, instruction width
ADDR_W, 16, PC/address width; all PC arithmetic is modulo 2^ADDR_W
DEPTH, 4, FIFO entries (power of 2, >=2); also bounds outstanding requests
IMM_W, 12, direct-jump offset field width, instr[IMM_W-1:0]
OPC_W, 4, opcode field width, instr[DATA_W-1 -: OPC_W]
JMP_OPC, 4'b1101, direct-jump opcode
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hlt  in  1  stop issuing new fetches
redirect_valid  in  1  execute-stage redirect (taken branch or jr)
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in request order, latency >=1
imem_rdata  in  DATA_W  response instruction
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_instr  out  DATA_W  FIFO head instruction
out_pc  out  ADDR_W  FIFO head PC
busy  out  1  outstanding requests != 0 or FIFO not empty

Behaviour:
- Reset (sync, rst=1 at clk edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req=0, out_valid=0, busy=0, out_instr/out_pc=0.
- Issue: imem_req = !hlt && !rst && (fifo_count + outstanding < DEPTH). imem_addr=fetch_pc. On req&&gnt: fetch_pc+=1 (wraps at 2^ADDR_W), outstanding+=1. The request is held stable until granted unless a redirect occurs.
- Response: on imem_rvalid: outstanding-=1. If drop_cnt>0, drop_cnt-=1 and discard. Otherwise push {resp_pc, rdata}, where resp_pc is tracked by a response-PC register advanced per accepted response.
- Predecode: an accepted (non-dropped) response with opcode==JMP_OPC is pushed, then fetch_pc and resp_pc become resp_pc+1+sign_extend(instr[IMM_W-1:0]). All still-outstanding requests are dropped: drop_cnt=outstanding after this cycle's grant and response.
- Redirect (redirect_valid=1): FIFO cleared, fetch_pc=resp_pc=redirect_pc. drop_cnt=outstanding after this cycle's grant and response. Any response in the same cycle is discarded. An out handshake in the same cycle is ignored (entry flushed).
- Priority: rst > redirect_valid > predecoded jump > sequential increment.
- Output: out_valid = FIFO non-empty. Pop on out_valid&&out_ready. Push and pop may occur in the same cycle at any occupancy. Head is registered (first-word fall-through). Min latency from grant to out_valid = memory latency + 1 cycle.
- Full: never overflows, because the issue rule reserves a slot per outstanding request. Empty: out_valid=0, and out_instr holds its last value.
- hlt: no new requests. Outstanding responses are still accepted and drained. A redirect under hlt still updates PC and flushes.
- A granted request in a redirect cycle is counted into drop_cnt.

Decomposition:
- Package if_pkg: JMP_OPC, OPC_W/IMM_W defaults, and a fetch-entry struct {pc, instr}.
- Sub-module if_fifo: parametrised sync FIFO (WIDTH=ADDR_W+DATA_W, DEPTH) with push/pop/flush/count.

Test Plan:
- Reset, gnt=1 always, latency 1, out_ready=1, no jumps -> out_pc 0,1,2,3… consecutive, one per cycle after 2-cycle fill.
- out_ready=0 with DEPTH=4 -> exactly 4 entries buffered, then imem_req=0; set out_ready=1 -> drains pc 0..3 in order, fetch resumes at 4.
- Word at pc 5 = 0xD003 -> next delivered pc 9. Word 0xDFFE at pc 5 -> next pc 4. Wrong-path responses are never output.
- Latency 3, redirect_valid with redirect_pc=0x0040 while 2 requests are outstanding -> both responses dropped, next out_pc=0x0040, busy clears after drain.
- fetch_pc=0xFFFF sequential -> next out_pc 0x0000. hlt=1 mid-stream -> req deasserts, outstanding responses still delivered. rst asserted mid-stream -> next cycle out_valid=0, imem_addr=RESET_PC.
